// File: rtl/ros2_eth_pkg.sv
// ros2_eth_pkg: shared state encoding, IP header size and header field widths
// for the ROS2 Ethernet TX path.
package ros2_eth_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    localparam int IP_HDR_SIZE = 20;

    localparam int DSCP_W  = 6;
    localparam int ECN_W   = 2;
    localparam int LEN_W   = 16;
    localparam int TTL_W   = 8;
    localparam int PROTO_W = 8;
    localparam int ADDR_W  = 32;

    typedef struct packed {
        logic [DSCP_W-1:0]  dscp;
        logic [ECN_W-1:0]   ecn;
        logic [LEN_W-1:0]   length;
        logic [TTL_W-1:0]   ttl;
        logic [PROTO_W-1:0] protocol;
        logic [ADDR_W-1:0]  source_ip;
        logic [ADDR_W-1:0]  dest_ip;
    } ip_hdr_t;

endpackage

// File: rtl/ros2_rr_arb2.sv
// ros2_rr_arb2: two-way arbiter; on a tie the requester that is not the last
// owner (pointer = index of last owner) wins, a lone requester always wins.
module ros2_rr_arb2
    import ros2_eth_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant
);

    assign grant[0] = req[0] & (~req[1] | pointer);
    assign grant[1] = req[1] & (~req[0] | ~pointer);

endmodule

// File: rtl/ros2_eth_tx_arbiter.sv
// ros2_eth_tx_arbiter: shares one IP TX header/payload port between two sources.
// Define ROS2_TX_ARB_FIXED_PRIO_EN to make source 0 always win ties (no pointer).
module ros2_eth_tx_arbiter
    import ros2_eth_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_s0_tx_hdr_valid,
    output logic               o_s0_tx_hdr_ready,
    input  logic [DSCP_W-1:0]  i_s0_tx_ip_dscp,
    input  logic [ECN_W-1:0]   i_s0_tx_ip_ecn,
    input  logic [LEN_W-1:0]   i_s0_tx_ip_length,
    input  logic [TTL_W-1:0]   i_s0_tx_ip_ttl,
    input  logic [PROTO_W-1:0] i_s0_tx_ip_protocol,
    input  logic [ADDR_W-1:0]  i_s0_tx_ip_source_ip,
    input  logic [ADDR_W-1:0]  i_s0_tx_ip_dest_ip,
    input  logic               i_s0_tx_payload_tvalid,
    input  logic [7:0]         i_s0_tx_payload_tdata,
    input  logic               i_s0_tx_payload_tlast,
    output logic               o_s0_tx_payload_tready,
    input  logic               i_s1_tx_hdr_valid,
    output logic               o_s1_tx_hdr_ready,
    input  logic [DSCP_W-1:0]  i_s1_tx_ip_dscp,
    input  logic [ECN_W-1:0]   i_s1_tx_ip_ecn,
    input  logic [LEN_W-1:0]   i_s1_tx_ip_length,
    input  logic [TTL_W-1:0]   i_s1_tx_ip_ttl,
    input  logic [PROTO_W-1:0] i_s1_tx_ip_protocol,
    input  logic [ADDR_W-1:0]  i_s1_tx_ip_source_ip,
    input  logic [ADDR_W-1:0]  i_s1_tx_ip_dest_ip,
    input  logic               i_s1_tx_payload_tvalid,
    input  logic [7:0]         i_s1_tx_payload_tdata,
    input  logic               i_s1_tx_payload_tlast,
    output logic               o_s1_tx_payload_tready,
    output logic               o_tx_hdr_valid,
    input  logic               i_tx_hdr_ready,
    output logic [DSCP_W-1:0]  o_tx_ip_dscp,
    output logic [ECN_W-1:0]   o_tx_ip_ecn,
    output logic [LEN_W-1:0]   o_tx_ip_length,
    output logic [TTL_W-1:0]   o_tx_ip_ttl,
    output logic [PROTO_W-1:0] o_tx_ip_protocol,
    output logic [ADDR_W-1:0]  o_tx_ip_source_ip,
    output logic [ADDR_W-1:0]  o_tx_ip_dest_ip,
    output logic               o_tx_payload_tvalid,
    output logic [7:0]         o_tx_payload_tdata,
    output logic               o_tx_payload_tlast,
    output logic               o_tx_payload_tkeep,
    output logic               o_tx_payload_tstrb,
    input  logic               i_tx_payload_tready,
    output logic [1:0]         o_grant
);

    logic [1:0] state;
    logic [1:0] grant;
    logic [1:0] arb_grant;
    logic [7:0] gap_cnt;
    logic       ptr;
    logic       sel;
    logic       idle_st;
    logic       hdr_st;
    logic       pay_st;
    logic       gap_st;
    logic       short_pkt;
    logic       pkt_end;
    ip_hdr_t    h0;
    ip_hdr_t    h1;
    ip_hdr_t    hs;

    assign idle_st = state == ST_IDLE;
    assign hdr_st  = state == ST_HDR;
    assign pay_st  = state == ST_PAYLOAD;
    assign gap_st  = state == ST_GAP;
    assign sel     = grant[1];

    ros2_rr_arb2 u_arb (
        .req     ({i_s1_tx_hdr_valid, i_s0_tx_hdr_valid} & {2{i_enable}}),
        .pointer (ptr),
        .grant   (arb_grant)
    );

`ifdef ROS2_TX_ARB_FIXED_PRIO_EN
    assign ptr = 1'b1;
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) ptr <= 1'b1;
        else if (idle_st && |arb_grant) ptr <= arb_grant[1];
    end
`endif

    assign h0 = {i_s0_tx_ip_dscp, i_s0_tx_ip_ecn, i_s0_tx_ip_length, i_s0_tx_ip_ttl,
                 i_s0_tx_ip_protocol, i_s0_tx_ip_source_ip, i_s0_tx_ip_dest_ip};
    assign h1 = {i_s1_tx_ip_dscp, i_s1_tx_ip_ecn, i_s1_tx_ip_length, i_s1_tx_ip_ttl,
                 i_s1_tx_ip_protocol, i_s1_tx_ip_source_ip, i_s1_tx_ip_dest_ip};
    assign hs = sel ? h1 : h0;

    assign o_grant        = grant;
    assign o_tx_hdr_valid = hdr_st;
    assign {o_tx_ip_dscp, o_tx_ip_ecn, o_tx_ip_length, o_tx_ip_ttl,
            o_tx_ip_protocol, o_tx_ip_source_ip, o_tx_ip_dest_ip} = hdr_st ? hs : '0;
    assign o_s0_tx_hdr_ready = hdr_st & grant[0] & i_tx_hdr_ready;
    assign o_s1_tx_hdr_ready = hdr_st & grant[1] & i_tx_hdr_ready;

    assign o_tx_payload_tvalid = pay_st & (sel ? i_s1_tx_payload_tvalid : i_s0_tx_payload_tvalid);
    assign o_tx_payload_tdata  = pay_st ? (sel ? i_s1_tx_payload_tdata : i_s0_tx_payload_tdata) : '0;
    assign o_tx_payload_tlast  = pay_st & (sel ? i_s1_tx_payload_tlast : i_s0_tx_payload_tlast);
    assign o_tx_payload_tkeep  = 1'b0;
    assign o_tx_payload_tstrb  = 1'b0;
    assign o_s0_tx_payload_tready = pay_st & grant[0] & i_tx_payload_tready;
    assign o_s1_tx_payload_tready = pay_st & grant[1] & i_tx_payload_tready;

    // A header-only packet ends on its header handshake; otherwise on the tlast beat.
    assign short_pkt = hs.length <= LEN_W'(IP_HDR_SIZE);
    assign pkt_end   = (hdr_st & i_tx_hdr_ready & short_pkt) |
                       (o_tx_payload_tvalid & i_tx_payload_tready & o_tx_payload_tlast);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            grant   <= '0;
            gap_cnt <= '0;
        end else if (idle_st && |arb_grant) begin
            state <= ST_HDR;
            grant <= arb_grant;
        end else if (hdr_st && i_tx_hdr_ready && !short_pkt) begin
            state <= ST_PAYLOAD;
        end else if (pkt_end) begin
            state   <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            grant   <= '0;
            gap_cnt <= '0;
        end else if (gap_st) begin
            gap_cnt <= gap_cnt + 8'd1;
            if (gap_cnt == 8'(GAP_CYCLES - 1)) state <= ST_IDLE;
        end
    end

endmodule

// File: doc/ros2_eth_tx_arbiter.md
ROS2_ETH_TX_ARBITER -- requirements
Module: ros2_eth_tx_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 0: minimum idle cycles between packet end and next grant, range 0..255.
REQ-002 SHALL have port i_clk, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port i_enable, input, 1 bit: allows new grants when high.
REQ-005 SHALL have ports i_sN_tx_hdr_valid, input, 1 bit, and o_sN_tx_hdr_ready, output, 1 bit, for N=0,1: per-source header handshake.
REQ-006 SHALL have i_sN_tx_ip_{dscp,ecn,length,ttl,protocol,source_ip,dest_ip}, input, widths 6/2/16/8/8/32/32, for N=0,1: source header fields, held stable while valid.
REQ-007 SHALL have i_sN_tx_payload_{tvalid,tdata,tlast}, input, widths 1/8/1, and o_sN_tx_payload_tready, output, 1 bit, for N=0,1: source payload streams.
REQ-008 SHALL have o_tx_hdr_valid, output, 1 bit; i_tx_hdr_ready, input, 1 bit; o_tx_ip_* outputs, same widths as REQ-006: shared IP TX header port.
REQ-009 SHALL have o_tx_payload_{tvalid,tdata,tlast,tkeep,tstrb}, output, widths 1/8/1/1/1, and i_tx_payload_tready, input, 1 bit: shared payload port.
REQ-010 SHALL have o_grant, output, 2 bits: one-hot owner, 0 when idle.

Function
REQ-011 SHALL implement states IDLE, HDR, PAYLOAD, GAP.
- IDLE: grant when i_enable is high and any i_sN_tx_hdr_valid is high; register o_grant; next state HDR.
- HDR: o_tx_hdr_valid=1; o_tx_ip_* are combinationally muxed from the granted source.
- On i_tx_hdr_ready: o_sN_tx_hdr_ready pulses for 1 cycle to the owner only.
- Next state from HDR: PAYLOAD if length>20; if length<=20, GAP when GAP_CYCLES>0, else IDLE.
REQ-012 PAYLOAD SHALL pass tvalid/tdata/tlast from the owner and route i_tx_payload_tready to the owner only; non-owners see tready=0.
- Leave PAYLOAD on a beat where tvalid&tready&tlast is true.
- Next state: GAP when GAP_CYCLES>0, else IDLE.
REQ-013 GAP SHALL count GAP_CYCLES cycles, then go to IDLE; o_grant is 0 in GAP and IDLE.
REQ-014 Latency: valid sampled in IDLE SHALL give o_tx_hdr_valid on the next cycle; back-to-back packets with GAP_CYCLES=0 SHALL have exactly one IDLE cycle between them.
REQ-015 Arbitration SHALL be round-robin using a last-owner pointer.
- When both sources request, the source that is not the last owner wins.
- When one source requests, it wins regardless of the pointer.
REQ-016 i_enable low SHALL only block grants in IDLE; an in-flight packet SHALL complete.
REQ-017 o_tx_payload_tkeep and o_tx_payload_tstrb SHALL be constant 0.
REQ-018 All shared outputs SHALL be 0 when no source is granted or the state does not use them.
REQ-019 A source dropping hdr_valid during HDR is a protocol violation; the arbiter SHALL keep the grant anyway.

Reset
REQ-020 i_rst high SHALL asynchronously force:
- state IDLE, o_grant=0, gap counter 0;
- last-owner pointer=1, so source 0 wins the first tie;
- every output 0.
REQ-021 Reset mid-packet SHALL abandon the packet; no tlast is emitted.

Configuration
REQ-022 With macro ROS2_TX_ARB_FIXED_PRIO_EN defined, source 0 SHALL always win ties and the pointer SHALL be removed.
REQ-023 Without ROS2_TX_ARB_FIXED_PRIO_EN, round-robin per REQ-015 SHALL apply.

Structure
REQ-024 A shared package ros2_eth_pkg SHALL hold the state encoding, IP_HDR_SIZE=20, and the header field widths.
REQ-025 Arbitration decision SHALL be a sub-module ros2_rr_arb2: inputs req[1:0], pointer; output one-hot grant.

Verification
REQ-026 Source 0 only, length=28, 8 beats with tready=1 -> o_grant=01; header on cycle after valid; 8 bytes; tlast on byte 8; then IDLE.
REQ-027 Both request, length=20 each -> s0 header accepted, no payload, then s1 granted after one IDLE cycle.
REQ-028 Both continuously request, 3 packets each -> grant order 0,1,0,1,0,1; with FIXED_PRIO_EN -> 0,0,0, then 1,1,1.
REQ-029 i_tx_payload_tready toggles 1010 during s1 payload -> o_s1 tready mirrors it; o_s0 tready=0; no beats lost.
REQ-030 GAP_CYCLES=3, back-to-back packets -> exactly 3 GAP cycles plus 1 IDLE cycle between tlast and next o_tx_hdr_valid.
REQ-031 i_rst pulsed mid-PAYLOAD -> all outputs 0 immediately; next tie grants source 0.
